mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_stage_ctrl_if.sv | 38 +++
 rtl/mem_stage_ctrl_dmem_array.sv | 30 +++
 rtl/mem_stage_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage controller:
// state encoding, data-memory geometry and the access-fault classifier.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam int XLEN           = 64;
  localparam int DMEM_DEPTH_DEF = 1024;
  localparam int OFFSET_W       = 3;
  localparam int REG_ADDR_W     = 5;
  localparam int CNT_W          = 3;

  // A memory access faults when misaligned to a doubleword, beyond the array,
  // or when it asks to read and write at the same time.
  function automatic logic mem_fault(
    input logic            rd,
    input logic            wr,
    input logic [XLEN-1:0] addr,
    input int              depth
  );
    logic            misaligned;
    logic            out_of_range;
    logic [XLEN-1:0] dw_index;
    logic [XLEN-1:0] limit;
    dw_index     = addr >> OFFSET_W;
    limit        = XLEN'(unsigned'(depth));
    misaligned   = |addr[OFFSET_W-1:0];
    out_of_range = (dw_index >= limit);
    return ((rd | wr) & (misaligned | out_of_range)) | (rd & wr);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// EX/MEM request and MEM/WB result handshake bundle for mem_stage_ctrl.
interface mem_stage_ctrl_if;
  import mem_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic                  memtoreg;
  logic                  regwrite;
  logic [XLEN-1:0]       address;
  logic [XLEN-1:0]       write_data;
  logic [REG_ADDR_W-1:0] write_reg;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       alu_result_out;
  logic [XLEN-1:0]       read_data_out;
  logic [REG_ADDR_W-1:0] write_reg_out;
  logic                  memtoreg_out;
  logic                  regwrite_out;
  logic                  inv_mem_addr;

  modport master (
    output in_valid, mem_read, mem_write, memtoreg, regwrite,
           address, write_data, write_reg, out_ready,
    input  in_ready, out_valid, alu_result_out, read_data_out,
           write_reg_out, memtoreg_out, regwrite_out, inv_mem_addr
  );

  modport slave (
    input  in_valid, mem_read, mem_write, memtoreg, regwrite,
           address, write_data, write_reg, out_ready,
    output in_ready, out_valid, alu_result_out, read_data_out,
           write_reg_out, memtoreg_out, regwrite_out, inv_mem_addr
  );

endinterface

// File: rtl/mem_stage_ctrl_dmem_array.sv
// Doubleword data memory: synchronous write, registered read, contents
// deliberately not reset so state survives a pipeline reset.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller with fixed-latency data memory access.
// Optional MEM_FAULT_TRAP_EN: a faulting access halts the stage until reset.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_ctrl_if.slave  bus,
  output logic             halted
);

  localparam int              AW       = $clog2(DMEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;

  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic                  r_memtoreg;
  logic                  r_regwrite;
  logic                  r_read;
  logic                  r_write;
  logic                  r_fault;

  logic                  w_accept;
  logic                  w_fault;
  logic                  w_is_mem;
  logic                  w_last_access;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic [XLEN-1:0]       w_rdata;

  assign bus.in_ready  = (r_state == ST_IDLE) & ~rst;
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign w_fault       = mem_fault(bus.mem_read, bus.mem_write, bus.address, DMEM_DEPTH);
  assign w_is_mem      = bus.mem_read | bus.mem_write;
  assign w_last_access = (r_state == ST_ACCESS) && (r_cnt == LAST_CNT);
  // Reset wins over the final access cycle so an aborted store never lands.
  assign w_mem_we      = w_last_access & r_write & ~rst;
  assign w_mem_re      = w_last_access & r_read;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_next = '0;
          if (w_is_mem && !w_fault) begin
            w_state_next = ST_ACCESS;
          end else begin
            w_state_next = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (w_last_access) begin
          w_state_next = ST_RESP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
`ifdef MEM_FAULT_TRAP_EN
          w_state_next = r_fault ? ST_HALT : ST_IDLE;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
      ST_HALT: begin
`ifdef MEM_FAULT_TRAP_EN
        w_state_next = ST_HALT;
`else
        w_state_next = ST_IDLE;
`endif
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Faulting requests are captured with read/write/regwrite stripped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wreg     <= '0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_fault    <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= bus.address;
      r_wdata    <= bus.write_data;
      r_wreg     <= bus.write_reg;
      r_memtoreg <= bus.memtoreg;
      r_regwrite <= bus.regwrite & ~w_fault;
      r_read     <= bus.mem_read & ~w_fault;
      r_write    <= bus.mem_write & ~w_fault;
      r_fault    <= w_fault;
    end
  end

  dmem_array #(
    .DEPTH (DMEM_DEPTH),
    .WIDTH (XLEN),
    .AW    (AW)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (r_addr[OFFSET_W +: AW]),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.out_valid      = (r_state == ST_RESP);
  assign bus.alu_result_out = r_addr;
  assign bus.write_reg_out  = r_wreg;
  assign bus.memtoreg_out   = r_memtoreg;
  assign bus.regwrite_out   = r_regwrite;
  assign bus.read_data_out  = (bus.out_valid && r_read) ? w_rdata : '0;
  assign bus.inv_mem_addr   = bus.out_valid & r_fault;

`ifdef MEM_FAULT_TRAP_EN
  assign halted = (r_state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed scoreboard bench for mem_stage_ctrl (LATENCY=2, DMEM_DEPTH=1024).
module tb_mem_stage_ctrl;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic        inv;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic halted;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [63:0] model [int];

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.LATENCY(LAT), .DMEM_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr, input logic m2r,
                     input logic rw, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [4:0] wreg, input int hold);
    exp_t e;
    exp_t got;
    logic flt;
    int   n;
    flt = (rd && wr) || ((rd || wr) && ((addr[2:0] != 3'd0) || ((addr >> 3) >= 64'(DEPTH))));
    e.alu   = addr;
    e.wreg  = wreg;
    e.m2r   = m2r;
    e.rw    = rw && !flt;
    e.inv   = flt;
    e.rdata = (rd && !flt) ? model[int'(addr >> 3)] : 64'd0;
    e.lat   = ((rd || wr) && !flt) ? 1 + LAT : 1;
    if (wr && !flt) model[int'(addr >> 3)] = wdata;
    sb.push_back(e);

    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid   = 1'b1;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.memtoreg   = m2r;
    bus.regwrite   = rw;
    bus.address    = addr;
    bus.write_data = wdata;
    bus.write_reg  = wreg;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    chk({tag, " latency"}, 64'(n), 64'(got.lat));

    for (int h = 0; h <= hold; h++) begin
      chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " alu"}, bus.alu_result_out, got.alu);
      chk({tag, " rdata"}, bus.read_data_out, got.rdata);
      chk({tag, " wreg"}, 64'(bus.write_reg_out), 64'(got.wreg));
      chk({tag, " regwrite"}, 64'(bus.regwrite_out), 64'(got.rw));
      chk({tag, " memtoreg"}, 64'(bus.memtoreg_out), 64'(got.m2r));
      chk({tag, " inv"}, 64'(bus.inv_mem_addr), 64'(got.inv));
      chk({tag, " busy"}, 64'(bus.in_ready), 64'd0);
      if (h < hold) @(negedge clk);
    end

    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " idle valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " idle rdata"}, bus.read_data_out, 64'd0);
    chk({tag, " idle inv"}, 64'(bus.inv_mem_addr), 64'd0);
`ifdef MEM_FAULT_TRAP_EN
    if (flt) begin
      chk({tag, " halted"}, 64'(halted), 64'd1);
      repeat (3) @(negedge clk);
      chk({tag, " halt ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, " halt held"}, 64'(halted), 64'd1);
      pulse_reset();
      chk({tag, " unhalt"}, 64'(halted), 64'd0);
    end else begin
      chk({tag, " ready after"}, 64'(bus.in_ready), 64'd1);
    end
`else
    chk({tag, " ready after"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " halted"}, 64'(halted), 64'd0);
`endif
    $display("txn %s rd=%0b wr=%0b addr=0x%0h lat=%0d rdata=0x%0h inv=%0b",
             tag, rd, wr, addr, n, got.rdata, got.inv);
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    bus.write_reg  = '0;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst halted", 64'(halted), 64'd0);
    chk("rst alu", bus.alu_result_out, 64'd0);
    chk("rst rdata", bus.read_data_out, 64'd0);
    chk("rst regwrite", 64'(bus.regwrite_out), 64'd0);
    chk("rst inv", 64'(bus.inv_mem_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst in_ready", 64'(bus.in_ready), 64'd1);

    txn("alu",      1'b0, 1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF3, 64'd0, 5'd3, 0);
    txn("st10",     1'b0, 1'b1, 1'b0, 1'b0, 64'h10, 64'hDEAD_BEEF, 5'd0, 0);
    txn("ld10",     1'b1, 1'b0, 1'b1, 1'b1, 64'h10, 64'd0, 5'd5, 0);
    txn("st1ff8",   1'b0, 1'b1, 1'b0, 1'b0, 64'h1FF8, 64'h0123_4567_89AB_CDEF, 5'd0, 0);
    txn("ld1ff8",   1'b1, 1'b0, 1'b1, 1'b1, 64'h1FF8, 64'd0, 5'd6, 0);
    txn("ld2000",   1'b1, 1'b0, 1'b1, 1'b1, 64'h2000, 64'd0, 5'd7, 0);
    txn("st14",     1'b0, 1'b1, 1'b0, 1'b0, 64'h14, 64'hBAD0_BAD0, 5'd0, 0);
    txn("ld10b",    1'b1, 1'b0, 1'b1, 1'b1, 64'h10, 64'd0, 5'd8, 0);
    txn("rdwr18",   1'b1, 1'b1, 1'b1, 1'b1, 64'h18, 64'h77, 5'd9, 0);
    txn("ld10hold", 1'b1, 1'b0, 1'b1, 1'b1, 64'h10, 64'd0, 5'd10, 5);
    txn("st20",     1'b0, 1'b1, 1'b0, 1'b0, 64'h20, 64'h1111, 5'd0, 0);

    // Store aborted by reset in its first access cycle.
    chk("abort in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid   = 1'b1;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b1;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.address    = 64'h20;
    bus.write_data = 64'h55;
    bus.write_reg  = 5'd4;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abort access", 64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort in_ready rst", 64'(bus.in_ready), 64'd0);
    chk("abort alu", bus.alu_result_out, 64'd0);
    chk("abort wreg", 64'(bus.write_reg_out), 64'd0);
    chk("abort rdata", bus.read_data_out, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort idle", 64'(bus.in_ready), 64'd1);
    $display("txn abort_st20 addr=0x20 reset in first access cycle");

    txn("ld20",     1'b1, 1'b0, 1'b1, 1'b1, 64'h20, 64'd0, 5'd11, 0);
    txn("ldhi",     1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0010, 64'd0, 5'd12, 0);
    txn("alu2",     1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_0000_FFFF_0001, 64'd0, 5'd31, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
